// File: rtl/adder_result_depacketizer_if.sv
// adder_result_depacketizer_if: packet input and result output handshakes.
// master drives in_valid/in_packet/out_ready, slave (the depacketizer) drives the rest.
interface adder_result_depacketizer_if #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 47
);
    logic              in_valid;
    logic              in_ready;
    logic [PWIDTH-1:0] in_packet;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic [2:0]        out_src;
    logic [7:0]        out_index;
    modport master (
        output in_valid, in_packet, out_ready,
        input  in_ready, out_valid, out_data, out_src, out_index
    );
    modport slave (
        input  in_valid, in_packet, out_ready,
        output in_ready, out_valid, out_data, out_src, out_index
    );
endinterface

// File: rtl/adder_result_depacketizer.sv
// adder_result_depacketizer: checks adder-result packets, buffers Psums with source and 1-based index.
// Ports: clk, reset (sync, active-high), bus (packet in / result out handshakes),
// drop_count (saturating rejected-packet count), done (NUM_RESULTS results delivered, sticky).
module adder_result_depacketizer #(
    parameter int          DWIDTH      = 8,
    parameter int          PWIDTH      = 47,
    parameter logic [2:0]  MY_ADDR     = 3'b110,
    parameter logic [2:0]  SRC_ADDR    = 3'b100,
    parameter logic [31:0] PAD_VALUE   = 32'h0000FFFF,
    parameter int          DEPTH       = 4,
    parameter int          NUM_RESULTS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    adder_result_depacketizer_if.slave   bus,
    output logic [7:0]                   drop_count,
    output logic                         done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 3 + DWIDTH + 8;
    typedef enum logic [1:0] {IDLE, HOLD, FULL, DONE} state_t;
    state_t          state;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count, count_n;
    logic [7:0]      idx, delivered;
    logic            good, take, push, pop, last;
    assign good = bus.in_packet[DWIDTH+38] &&
                  bus.in_packet[DWIDTH+37:DWIDTH+35] == MY_ADDR &&
                  bus.in_packet[DWIDTH+34:DWIDTH+32] == SRC_ADDR &&
                  bus.in_packet[DWIDTH+31:DWIDTH] == PAD_VALUE;
    // Accept only while the FSM says there is room and the layer is not finished.
    assign bus.in_ready  = state == IDLE || state == HOLD;
    assign bus.out_valid = count != '0;
    assign {bus.out_src, bus.out_data, bus.out_index} = mem[rd_ptr];
    assign take    = bus.in_valid && bus.in_ready;
    assign push    = take && good;
    assign pop     = bus.out_valid && bus.out_ready;
    assign count_n = count + CW'(push) - CW'(pop);
    // This dequeue delivers the final result of the layer.
    assign last    = pop && delivered == 8'(NUM_RESULTS - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            idx        <= 8'd1;
            delivered  <= '0;
            drop_count <= '0;
            done       <= 1'b0;
            state      <= IDLE;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.in_packet[DWIDTH+34:DWIDTH+32], bus.in_packet[DWIDTH-1:0], idx};
                wr_ptr      <= wr_ptr + 1'b1;
                idx         <= idx + 8'd1;
            end
            if (take && !good && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                delivered <= delivered + 8'd1;
            end
            count <= count_n;
            done  <= done || last;
            state <= (done || last) ? DONE :
                     count_n == '0 ? IDLE :
                     count_n == CW'(DEPTH) ? FULL : HOLD;
        end
    end
endmodule

// File: tb/tb_adder_result_depacketizer.sv
// tb_adder_result_depacketizer: scoreboard bench with directed packets for the depacketizer.
module tb_adder_result_depacketizer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] drop_count;
    logic       done;
    int         vectors = 0;
    int         miscompares = 0;
    logic [18:0] sb [$];
    logic [7:0] exp_idx = 8'd1;
    logic [7:0] exp_drop = 8'd0;
    logic [18:0] head;

    always #5 clk = ~clk;

    adder_result_depacketizer_if #(.DWIDTH(8), .PWIDTH(47)) bus ();

    adder_result_depacketizer dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .drop_count (drop_count),
        .done       (done)
    );

    function automatic logic [46:0] good_pkt(input logic [7:0] psum);
        return {1'b1, 3'b110, 3'b100, 32'h0000FFFF, psum};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake on the output pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got data %0h index %0h with nothing expected",
                         bus.out_data, bus.out_index);
            end else begin
                head = sb.pop_front();
                check("out_src",   {29'd0, bus.out_src},  {29'd0, head[18:16]});
                check("out_data",  {24'd0, bus.out_data}, {24'd0, head[15:8]});
                check("out_index", {24'd0, bus.out_index}, {24'd0, head[7:0]});
            end
        end
    end

    task automatic send(input logic [46:0] p, input bit ok);
        int n = 0;
        bus.in_packet = p;
        bus.in_valid  = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: packet %0h never accepted", p);
                bus.in_valid = 1'b0;
                return;
            end
        end
        if (ok) begin
            sb.push_back({3'b100, p[7:0], exp_idx});
            exp_idx++;
        end else if (exp_drop != 8'hFF) exp_drop++;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        exp_idx  = 8'd1;
        exp_drop = 8'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_packet = '0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data",   {24'd0, bus.out_data},  32'd0);
        check("rst_out_src",    {29'd0, bus.out_src},   32'd0);
        check("rst_out_index",  {24'd0, bus.out_index}, 32'd0);
        check("rst_drop_count", {24'd0, drop_count},    32'd0);
        check("rst_done",       {31'd0, done},          32'd0);
        check("rst_in_ready",   {31'd0, bus.in_ready},  32'd1);

        // Single good packet: visible right after the accept edge.
        bus.out_ready = 1'b1;
        send(47'h740000FFFF2A, 1'b1);
        check("lat_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("lat_out_data",  {24'd0, bus.out_data},  32'h2A);
        check("lat_out_src",   {29'd0, bus.out_src},   32'd4);
        check("lat_out_index", {24'd0, bus.out_index}, 32'd1);
        tick();
        check("lat_drop_count", {24'd0, drop_count}, 32'd0);
        check("lat_empty", {31'd0, bus.out_valid}, 32'd0);

        // Stall until full, then release and let the fifth packet in.
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send(good_pkt(8'(k)), 1'b1);
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("full_head",     {24'd0, bus.out_data}, 32'h01);
        fork
            send(good_pkt(8'h05), 1'b1);
            begin
                repeat (3) tick();
                check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
                check("stall_hold",     {24'd0, bus.out_data}, 32'h01);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Bad packets are consumed and counted but never delivered.
        do_reset();
        bus.out_ready = 1'b1;
        send(47'h6C0000FFFF2A, 1'b0);
        check("bad_dest_valid", {31'd0, bus.out_valid}, 32'd0);
        send(47'h340000FFFF2A, 1'b0);
        check("bad_type_valid", {31'd0, bus.out_valid}, 32'd0);
        send(47'h74000000002A, 1'b0);
        check("bad_pad_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bad_drop_count", {24'd0, drop_count}, {24'd0, exp_drop});
        send(47'h740000FFFF2A, 1'b1);
        drain();

        // Done after NUM_RESULTS deliveries, then no more acceptance.
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) send(good_pkt(8'(8'h40 + k)), 1'b1);
        check("done_early", {31'd0, done}, 32'd0);
        tick();
        check("done_set",       {31'd0, done},         32'd1);
        check("done_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        bus.in_packet = good_pkt(8'h77);
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("done_block", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        check("done_no_out", {31'd0, bus.out_valid}, 32'd0);
        check("done_sticky", {31'd0, done}, 32'd1);

        // Reset with entries buffered discards them.
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(good_pkt(8'(8'h60 + k)), 1'b1);
        send(47'h340000FFFF2A, 1'b0);
        check("mid_drop", {24'd0, drop_count}, 32'd1);
        check("mid_valid", {31'd0, bus.out_valid}, 32'd1);
        do_reset();
        check("mid_rst_valid",    {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_drop",     {24'd0, drop_count},    32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready},  32'd1);
        check("mid_rst_done",     {31'd0, done},          32'd0);
        bus.out_ready = 1'b1;
        send(good_pkt(8'h55), 1'b1);
        drain();

        // Simultaneous push and pop with two entries held.
        do_reset();
        bus.out_ready = 1'b0;
        send(good_pkt(8'h10), 1'b1);
        send(good_pkt(8'h11), 1'b1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_packet = good_pkt(8'(8'h20 + k));
            bus.in_valid  = 1'b1;
            @(negedge clk);
            check("sim_in_ready", {31'd0, bus.in_ready}, 32'd1);
            sb.push_back({3'b100, 8'(8'h20 + k), exp_idx});
            exp_idx++;
            tick();
            check("sim_occupancy", sb.size(), 32'd2);
        end
        bus.in_valid = 1'b0;
        drain();
        check("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adder_result_depacketizer.md
Name: adder_result_depacketizer

Overview:
- Receive end of the adder-result packet format: the memory node's depacketizer for final-output packets sent by the safe adder's packetizer.
- Accepts 47-bit packets, checks the header, strips the header, and buffers each Psum in a small FIFO.
- Presents each Psum to the memory write path with its source address and a 1-based result index.
- Counts dropped packets and flags done after NUM_RESULTS results have been delivered.

Parameters:
- DWIDTH, 8, Psum data width; packet bits [DWIDTH-1:0].
- PWIDTH, 47, packet width; must equal DWIDTH+39.
- MY_ADDR, 3'b110, destination address of this node (memory).
- SRC_ADDR, 3'b100, expected source address (safe adder).
- PAD_VALUE, 32'h0000FFFF, expected filler field.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- NUM_RESULTS, 16, results expected per layer.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  packet valid.
- in_ready  out  1  depacketizer can accept.
- in_packet  in  PWIDTH  packet.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_data  out  DWIDTH  Psum.
- out_src  out  3  source address of packet.
- out_index  out  8  1-based result number.
- drop_count  out  8  rejected packets, saturating.
- done  out  1  NUM_RESULTS results delivered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; all state updates on posedge clk.
- Reset values: FIFO empty, out_valid=0, out_data=0, out_src=0, out_index=0, drop_count=0, done=0, index counter=1, delivered count=0.
- Packet fields:
  - bit 46 = type flag; 1 = result/ifm.
  - [45:43] = dest.
  - [42:40] = src.
  - [39:8] = pad.
  - [DWIDTH-1:0] = Psum.
- Acceptance: a packet is taken when in_valid && in_ready.
  - in_ready = !full && !done, with no combinational dependency on out_ready.
- Good packet: type==1, dest==MY_ADDR, src==SRC_ADDR and pad==PAD_VALUE.
  - Enqueue {src, Psum, index counter}, then increment the index counter (8-bit, wraps 255→0).
- Bad packet: any check fails.
  - Packet is consumed but not enqueued.
  - drop_count increments, saturating at 255.
  - Index counter unchanged.
- Latency: an accepted good packet appears on out_* on the next cycle when the FIFO was empty (out_valid rises the cycle after the accept edge). There is no combinational pass-through.
- Output: out_valid = !empty. out_data, out_src and out_index reflect the FIFO head and hold stable while out_valid && !out_ready. Dequeue on out_valid && out_ready.
- Simultaneous enqueue and dequeue: legal when not full; occupancy is unchanged. When full, in_ready=0, so a same-cycle dequeue does not enable an enqueue; in_ready rises the next cycle.
- Wrap-around: read and write pointers are log2(DEPTH) bits with a separate occupancy count (0..DEPTH) for full/empty.
- Done: the delivered count increments on each dequeue. When it reaches NUM_RESULTS, done=1 on the following cycle and is sticky until reset.
  - While done: in_ready=0, and any remaining FIFO entries (none in legal use) still drain.
- Reset mid-operation: FIFO contents discarded, all counters cleared; out_valid=0 on the cycle after reset is sampled high.
- Required state machine: IDLE (empty) → HOLD (≥1 entry) → FULL (DEPTH entries) → DONE (sticky).

Test Plan:
- Good packet 0x740000FFFF2A, out_ready=1 → one cycle later out_valid=1, out_data=0x2A, out_src=3'b100, out_index=1; drop_count=0.
- Stall: out_ready=0; send Psum 0x01,0x02,0x03,0x04 then a fifth packet → in_ready=0 after the fourth accept. Raise out_ready → data 0x01..0x04 in order with indices 1..4, then the fifth is accepted.
- Bad packets, one each:
  - dest=3'b101 (0x6C0000FFFF2A).
  - type=0 (0x340000FFFF2A).
  - pad=0 (0x74000000002A).
  - Required: out_valid stays 0, drop_count=3, next good packet gets out_index=1.
- Done: NUM_RESULTS=16 good packets with out_ready=1 → done=1 the cycle after the 16th dequeue, in_ready=0 afterwards, a 17th packet is not accepted.
- Reset mid-stream: 3 entries buffered, reset high for 1 cycle → out_valid=0, drop_count=0; the next good packet has out_index=1.
- Simultaneous: FIFO holding 2 entries, in_valid and out_ready both high for 10 cycles → occupancy stays 2, indices remain contiguous, no loss or duplication.
